sbox_share_ctrl: RTL and testbench

Arbiter and sequencer that time-shares one 32-bit combinational S-box word unit (four parallel byte lookups) between two requesters. The first is the AES key-expansion path, which needs one 32-bit word substituted. The second is the round datapath, which needs a full 128-bit state substituted. It sits beside the single S-box instance in the CAN-SEC AES core and replaces a second S-box instance.

---
 rtl/sbox_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_sbox_share_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_ctrl.sv
// Arbiter/sequencer sharing one 32-bit S-box word unit between the key-expansion
// path (one word) and the round datapath (four words, most significant first).
module sbox_share_ctrl #(
    parameter int KEY_PRIORITY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_req_i,
    input  logic [31:0]  key_word_i,
    output logic         key_ack_o,
    output logic [31:0]  key_result_o,
    input  logic         blk_req_i,
    input  logic [127:0] blk_state_i,
    output logic         blk_ack_o,
    output logic [127:0] blk_result_o,
    output logic [31:0]  sbox_in_o,
    input  logic [31:0]  sbox_out_i,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEY  = 2'd1,
        S_BLK  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_wc;
    logic [1:0]    w_wc_nxt;
    logic          r_last_blk;
    logic          w_last_blk_nxt;
    logic          r_key_ack;
    logic          r_blk_ack;
    logic          w_key_ack_nxt;
    logic          w_blk_ack_nxt;
    logic [31:0]   r_key_result;
    logic [127:0]  r_blk_result;
    logic [95:0]   r_acc;
    logic [31:0]   w_sbox_in;
    logic          w_key_req_m;
    logic          w_blk_req_m;
    logic          w_grant_key;
    logic          w_grant_blk;

    // A request still held during its own ack cycle must not be granted again.
    always_comb begin
        w_key_req_m = key_req_i & ~r_key_ack;
        w_blk_req_m = blk_req_i & ~r_blk_ack;
        w_grant_key = 1'b0;
        w_grant_blk = 1'b0;
        if (w_key_req_m && w_blk_req_m) begin
            if ((KEY_PRIORITY != 0) || r_last_blk) begin
                w_grant_key = 1'b1;
            end else begin
                w_grant_blk = 1'b1;
            end
        end else begin
            w_grant_key = w_key_req_m;
            w_grant_blk = w_blk_req_m;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wc_nxt       = r_wc;
        w_last_blk_nxt = r_last_blk;
        w_key_ack_nxt  = 1'b0;
        w_blk_ack_nxt  = 1'b0;
        w_sbox_in      = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_key) begin
                    w_state_nxt = S_KEY;
                end else if (w_grant_blk) begin
                    w_state_nxt = S_BLK;
                    w_wc_nxt    = 2'd0;
                end
            end
            S_KEY: begin
                w_sbox_in      = key_word_i;
                w_key_ack_nxt  = 1'b1;
                w_last_blk_nxt = 1'b0;
                w_state_nxt    = S_IDLE;
            end
            S_BLK: begin
                case (r_wc)
                    2'd0:    w_sbox_in = blk_state_i[127:96];
                    2'd1:    w_sbox_in = blk_state_i[95:64];
                    2'd2:    w_sbox_in = blk_state_i[63:32];
                    default: w_sbox_in = blk_state_i[31:0];
                endcase
                if (r_wc == 2'd3) begin
                    w_blk_ack_nxt  = 1'b1;
                    w_last_blk_nxt = 1'b1;
                    w_wc_nxt       = 2'd0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_wc_nxt = r_wc + 2'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wc         <= 2'd0;
            r_last_blk   <= 1'b1;
            r_key_ack    <= 1'b0;
            r_blk_ack    <= 1'b0;
            r_key_result <= 32'd0;
            r_blk_result <= 128'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wc       <= w_wc_nxt;
            r_last_blk <= w_last_blk_nxt;
            r_key_ack  <= w_key_ack_nxt;
            r_blk_ack  <= w_blk_ack_nxt;
            if (r_state == S_KEY) begin
                r_key_result <= sbox_out_i;
            end
            if ((r_state == S_BLK) && (r_wc == 2'd3)) begin
                r_blk_result <= {r_acc, sbox_out_i};
            end
        end
    end

    // Accumulator needs no reset: every word is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (r_state == S_BLK) begin
            case (r_wc)
                2'd0:    r_acc[95:64] <= sbox_out_i;
                2'd1:    r_acc[63:32] <= sbox_out_i;
                2'd2:    r_acc[31:0]  <= sbox_out_i;
                default: r_acc        <= r_acc;
            endcase
        end
    end

    assign sbox_in_o    = w_sbox_in;
    assign key_ack_o    = r_key_ack;
    assign blk_ack_o    = r_blk_ack;
    assign key_result_o = r_key_result;
    assign blk_result_o = r_blk_result;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: one fixed-priority and one round-robin
// instance, each fed by a behavioural AES S-box word unit.
module tb_sbox_share_ctrl;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] b);
        logic [127:0] row;
        int           idx;
        row = SBOX_ROWS[b[7:4]];
        idx = 15 - int'(b[3:0]);
        return row[idx*8 +: 8];
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         key_req, blk_req, key_ack, blk_ack, busy;
    logic [31:0]  key_word, key_result, sbox_in, sbox_out;
    logic [127:0] blk_state, blk_result;
    logic         rr_key_req, rr_blk_req, rr_key_ack, rr_blk_ack, rr_busy;
    logic [31:0]  rr_key_word, rr_key_result, rr_sbox_in, rr_sbox_out;
    logic [127:0] rr_blk_state, rr_blk_result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign sbox_out    = sbox_word(sbox_in);
    assign rr_sbox_out = sbox_word(rr_sbox_in);

    sbox_share_ctrl #(.KEY_PRIORITY(1)) dut (
        .clk(clk), .rst(rst),
        .key_req_i(key_req), .key_word_i(key_word),
        .key_ack_o(key_ack), .key_result_o(key_result),
        .blk_req_i(blk_req), .blk_state_i(blk_state),
        .blk_ack_o(blk_ack), .blk_result_o(blk_result),
        .sbox_in_o(sbox_in), .sbox_out_i(sbox_out),
        .busy_o(busy)
    );

    sbox_share_ctrl #(.KEY_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .key_req_i(rr_key_req), .key_word_i(rr_key_word),
        .key_ack_o(rr_key_ack), .key_result_o(rr_key_result),
        .blk_req_i(rr_blk_req), .blk_state_i(rr_blk_state),
        .blk_ack_o(rr_blk_ack), .blk_result_o(rr_blk_result),
        .sbox_in_o(rr_sbox_in), .sbox_out_i(rr_sbox_out),
        .busy_o(rr_busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] BLK_A     = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BLK_A_RES = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;
    localparam logic [127:0] BLK_B     = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] BLK_B_RES = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;

    initial begin
        rst = 1'b1;
        key_req = 1'b0; blk_req = 1'b0; key_word = 32'd0; blk_state = 128'd0;
        rr_key_req = 1'b0; rr_blk_req = 1'b0; rr_key_word = 32'd0; rr_blk_state = 128'd0;
        tick(); tick();
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_key_ack", {127'd0, key_ack}, 128'd0);
        chk("rst_blk_ack", {127'd0, blk_ack}, 128'd0);
        chk("rst_key_result", {96'd0, key_result}, 128'd0);
        chk("rst_blk_result", blk_result, 128'd0);
        chk("rst_sbox_in", {96'd0, sbox_in}, 128'd0);
        chk("rst_rr_busy", {127'd0, rr_busy}, 128'd0);
        rst = 1'b0;
        tick();

        // key only
        key_word = 32'h00010253; key_req = 1'b1;
        tick();
        chk("key_t1_busy", {127'd0, busy}, 128'd1);
        chk("key_t1_sbox_in", {96'd0, sbox_in}, 128'h00010253);
        chk("key_t1_ack", {127'd0, key_ack}, 128'd0);
        tick();
        chk("key_t2_ack", {127'd0, key_ack}, 128'd1);
        chk("key_t2_result", {96'd0, key_result}, 128'h637c77ed);
        chk("key_t2_blk_ack", {127'd0, blk_ack}, 128'd0);
        chk("key_t2_busy", {127'd0, busy}, 128'd0);
        key_req = 1'b0;
        tick();
        chk("key_t3_ack", {127'd0, key_ack}, 128'd0);
        chk("key_t3_result_held", {96'd0, key_result}, 128'h637c77ed);
        chk("key_t3_busy", {127'd0, busy}, 128'd0);

        // block only
        blk_state = BLK_A; blk_req = 1'b1;
        tick();
        chk("blk_w0", {96'd0, sbox_in}, 128'h00112233);
        chk("blk_t1_busy", {127'd0, busy}, 128'd1);
        tick();
        chk("blk_w1", {96'd0, sbox_in}, 128'h44556677);
        tick();
        chk("blk_w2", {96'd0, sbox_in}, 128'h8899aabb);
        tick();
        chk("blk_w3", {96'd0, sbox_in}, 128'hccddeeff);
        chk("blk_t4_ack", {127'd0, blk_ack}, 128'd0);
        tick();
        chk("blk_t5_ack", {127'd0, blk_ack}, 128'd1);
        chk("blk_t5_result", blk_result, BLK_A_RES);
        chk("blk_t5_key_ack", {127'd0, key_ack}, 128'd0);
        chk("blk_t5_busy", {127'd0, busy}, 128'd0);
        blk_req = 1'b0;
        tick();
        chk("blk_t6_ack", {127'd0, blk_ack}, 128'd0);

        // simultaneous, key priority
        key_word = 32'hffffffff; key_req = 1'b1; blk_req = 1'b1;
        tick();
        chk("tie_t1_sbox_in", {96'd0, sbox_in}, 128'hffffffff);
        tick();
        chk("tie_t2_key_ack", {127'd0, key_ack}, 128'd1);
        chk("tie_t2_key_result", {96'd0, key_result}, 128'h16161616);
        chk("tie_t2_blk_ack", {127'd0, blk_ack}, 128'd0);
        key_req = 1'b0;
        tick();
        chk("tie_t3_sbox_in", {96'd0, sbox_in}, 128'h00112233);
        chk("tie_t3_key_ack", {127'd0, key_ack}, 128'd0);
        tick(); tick(); tick();
        chk("tie_t6_blk_ack", {127'd0, blk_ack}, 128'd0);
        tick();
        chk("tie_t7_blk_ack", {127'd0, blk_ack}, 128'd1);
        chk("tie_t7_blk_result", blk_result, BLK_A_RES);
        chk("tie_t7_key_ack", {127'd0, key_ack}, 128'd0);
        blk_req = 1'b0;
        tick();

        // key request arriving mid-block
        blk_state = BLK_B; blk_req = 1'b1;
        tick();
        tick();
        key_word = 32'h10203040; key_req = 1'b1;
        chk("mid_wc1_sbox_in", {96'd0, sbox_in}, 128'h04050607);
        tick(); tick();
        chk("mid_wc3_sbox_in", {96'd0, sbox_in}, 128'h0c0d0e0f);
        tick();
        chk("mid_blk_ack", {127'd0, blk_ack}, 128'd1);
        chk("mid_blk_result", blk_result, BLK_B_RES);
        chk("mid_key_ack_early", {127'd0, key_ack}, 128'd0);
        blk_req = 1'b0;
        tick();
        chk("mid_key_sbox_in", {96'd0, sbox_in}, 128'h10203040);
        chk("mid_key_busy", {127'd0, busy}, 128'd1);
        chk("mid_key_ack_pending", {127'd0, key_ack}, 128'd0);
        tick();
        chk("mid_key_ack", {127'd0, key_ack}, 128'd1);
        chk("mid_key_result", {96'd0, key_result}, 128'hcab70409);
        key_req = 1'b0;
        tick();

        // reset in the middle of a block
        blk_state = BLK_A; blk_req = 1'b1;
        tick(); tick(); tick();
        chk("rstmid_wc2_sbox_in", {96'd0, sbox_in}, 128'h8899aabb);
        rst = 1'b1; blk_req = 1'b0;
        #1;
        chk("rstmid_busy", {127'd0, busy}, 128'd0);
        chk("rstmid_blk_result", blk_result, 128'd0);
        chk("rstmid_key_result", {96'd0, key_result}, 128'd0);
        chk("rstmid_sbox_in", {96'd0, sbox_in}, 128'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_no_ack", {127'd0, blk_ack}, 128'd0);
        chk("rstmid_idle", {127'd0, busy}, 128'd0);
        blk_req = 1'b1;
        tick(); tick(); tick(); tick();
        chk("fresh_t4_ack", {127'd0, blk_ack}, 128'd0);
        chk("fresh_t4_result", blk_result, 128'd0);
        tick();
        chk("fresh_t5_ack", {127'd0, blk_ack}, 128'd1);
        chk("fresh_t5_result", blk_result, BLK_A_RES);
        blk_req = 1'b0;
        tick();

        // round-robin instance: a key grant first makes the next tie go to the block
        rr_key_word = 32'h00010253; rr_key_req = 1'b1;
        tick(); tick();
        chk("rr_key0_ack", {127'd0, rr_key_ack}, 128'd1);
        chk("rr_key0_result", {96'd0, rr_key_result}, 128'h637c77ed);
        rr_key_req = 1'b0;
        tick();
        rr_blk_state = BLK_A; rr_key_word = 32'hffffffff;
        rr_key_req = 1'b1; rr_blk_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("rr_c%0d_key_ack", c), {127'd0, rr_key_ack}, {127'd0, (c == 7)});
            chk($sformatf("rr_c%0d_blk_ack", c), {127'd0, rr_blk_ack}, {127'd0, (c == 5 || c == 12)});
            chk($sformatf("rr_c%0d_busy", c), {127'd0, rr_busy}, {127'd0, !(c == 5 || c == 7 || c == 12)});
            if (c == 1) chk("rr_first_blk_word", {96'd0, rr_sbox_in}, 128'h00112233);
            if (c == 5) chk("rr_blk_result", rr_blk_result, BLK_A_RES);
            if (c == 6) chk("rr_key_sbox_in", {96'd0, rr_sbox_in}, 128'hffffffff);
            if (c == 7) chk("rr_key_result", {96'd0, rr_key_result}, 128'h16161616);
            if (c == 12) begin
                rr_key_req = 1'b0;
                rr_blk_req = 1'b0;
            end
        end
        tick();
        chk("rr_end_busy", {127'd0, rr_busy}, 128'd0);
        chk("rr_end_key_ack", {127'd0, rr_key_ack}, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
